vga_sync_gen: RTL and testbench

- Parametrised VGA timing generator that replaces the separate per-axis sync blocks.
- Contains a pixel-tick divider, a horizontal counter and a vertical counter cascaded from it.
- Outputs are registered: hsync/vsync (polarity selectable), video_on, pixel coordinates and line/frame strobes.
- Sits between the system clock and the pixel-generation and graphics logic (pong objects, text overlay); one instance serves any resolution set by parameters.

---
 rtl/vga_timing_pkg.sv | 48 ++++
 rtl/sync_axis_counter.sv | 45 ++++
 rtl/vga_sync_gen.sv | 138 +++++++++++++
 tb/tb_vga_sync_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing presets, polarity constants and helpers
package vga_timing_pkg;

  // Sync polarity levels: the level a sync output takes while its pulse is active
  localparam int SYNC_ACTIVE_LOW  = 0;
  localparam int SYNC_ACTIVE_HIGH = 1;

  // Axis identifiers, used for naming and preset lookup
  typedef enum logic {
    AXIS_H = 1'b0,
    AXIS_V = 1'b1
  } axis_e;

  // One axis worth of timing, in pixels (H) or lines (V)
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
    int pol;
  } axis_timing_t;

  // Total period of an axis: visible region plus both porches and the sync pulse
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_H_POL    = SYNC_ACTIVE_LOW;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam int VGA640_V_POL    = SYNC_ACTIVE_LOW;
  localparam int H_TOTAL = axis_total(VGA640_H_ACTIVE, VGA640_H_FP, VGA640_H_SYNC, VGA640_H_BP);
  localparam int V_TOTAL = axis_total(VGA640_V_ACTIVE, VGA640_V_FP, VGA640_V_SYNC, VGA640_V_BP);

  // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high
  localparam axis_timing_t SVGA800_H = '{active: 800, fp: 40, sync: 128, bp: 88, pol: SYNC_ACTIVE_HIGH};
  localparam axis_timing_t SVGA800_V = '{active: 600, fp: 1, sync: 4, bp: 23, pol: SYNC_ACTIVE_HIGH};
  localparam int SVGA800_H_TOTAL = axis_total(SVGA800_H.active, SVGA800_H.fp, SVGA800_H.sync, SVGA800_H.bp);
  localparam int SVGA800_V_TOTAL = axis_total(SVGA800_V.active, SVGA800_V.fp, SVGA800_V.sync, SVGA800_V.bp);

endpackage

// File: rtl/sync_axis_counter.sv
// rtl/sync_axis_counter.sv - one timing axis: wrapping counter with sync and active decode
module sync_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int CNT_W  = 10,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int POL    = SYNC_ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             sync_i,
  output logic             active_i
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  // Decode boundaries sized to the counter so every compare is width-matched
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] ACTIVE_END = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic             ON_LVL     = (POL != SYNC_ACTIVE_LOW);

  // Wrap is qualified by step so the next axis advances only on the real last position
  assign wrap     = step && (cnt == LAST);
  assign sync_i   = ((cnt >= SYNC_FIRST) && (cnt <= SYNC_LAST)) ? ON_LVL : ~ON_LVL;
  assign active_i = (cnt < ACTIVE_END);

  // Position counter: advance on step, return to zero after the last position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= (cnt == LAST) ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - parametrised VGA timing generator with registered, aligned outputs
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CNT_W    = 10,
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int H_POL    = VGA640_H_POL,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter int V_POL    = VGA640_V_POL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             p_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_end,
  output logic             frame_end
);

  localparam int H_TOT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // A divide-by-one still needs a one-bit phase register that simply sits at zero
  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  // Inactive sync levels, used out of reset and outside the pulse
  localparam logic H_IDLE = (H_POL == SYNC_ACTIVE_LOW);
  localparam logic V_IDLE = (V_POL == SYNC_ACTIVE_LOW);

  // Parameter sets that cannot produce a usable raster stop elaboration
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be at least 1");
  end
  if ((H_SYNC < 1) || (V_SYNC < 1)) begin : g_bad_sync
    $error("vga_sync_gen: sync pulse width must be at least one");
  end
  if ((H_TOT > (1 << CNT_W)) || (V_TOT > (1 << CNT_W))) begin : g_bad_total
    $error("vga_sync_gen: axis total does not fit in CNT_W bits");
  end

  logic [DIV_W-1:0] div_cnt;
  logic             tick_i;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_sync_i;
  logic             v_sync_i;
  logic             h_active_i;
  logic             v_active_i;

  assign tick_i = en && (div_cnt == DIV_LAST);

  // Pixel-tick divider: phase holds while en is low so resuming skips nothing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_ONE;
    end
  end

  sync_axis_counter #(
    .CNT_W  (CNT_W),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL)
  ) u_h_axis (
    .clk      (clk),
    .reset    (reset),
    .step     (tick_i),
    .cnt      (h_cnt),
    .wrap     (h_wrap),
    .sync_i   (h_sync_i),
    .active_i (h_active_i)
  );

  // The vertical axis steps once per line, on the same tick that wraps the line
  sync_axis_counter #(
    .CNT_W  (CNT_W),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL)
  ) u_v_axis (
    .clk      (clk),
    .reset    (reset),
    .step     (h_wrap),
    .cnt      (v_cnt),
    .wrap     (v_wrap),
    .sync_i   (v_sync_i),
    .active_i (v_active_i)
  );

  // Output stage: every output is one clk behind the counters; strobes drop while paused
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_tick    <= 1'b0;
      hsync     <= H_IDLE;
      vsync     <= V_IDLE;
      video_on  <= 1'b0;
      pixel_x   <= '0;
      pixel_y   <= '0;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else if (en) begin
      p_tick    <= tick_i;
      hsync     <= h_sync_i;
      vsync     <= v_sync_i;
      video_on  <= h_active_i && v_active_i;
      pixel_x   <= h_cnt;
      pixel_y   <= v_cnt;
      line_end  <= h_wrap;
      frame_end <= v_wrap;
    end else begin
      p_tick    <= 1'b0;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen, default and tiny raster configs
module tb_vga_sync_gen;

  typedef struct packed {
    logic       p_tick;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       line_end;
    logic       frame_end;
    logic [9:0] px;
    logic [9:0] py;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, en_a, rst_b, en_b;

  logic       a_p_tick, a_hsync, a_vsync, a_video_on, a_line_end, a_frame_end;
  logic [9:0] a_px, a_py;
  logic       b_p_tick, b_hsync, b_vsync, b_video_on, b_line_end, b_frame_end;
  logic [9:0] b_px, b_py;

  exp_t qa[$];
  exp_t qb[$];
  exp_t la, lb;
  int   na, nb;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  vga_sync_gen u_dut_a (
    .clk       (clk),
    .reset     (rst_a),
    .en        (en_a),
    .p_tick    (a_p_tick),
    .hsync     (a_hsync),
    .vsync     (a_vsync),
    .video_on  (a_video_on),
    .pixel_x   (a_px),
    .pixel_y   (a_py),
    .line_end  (a_line_end),
    .frame_end (a_frame_end)
  );

  vga_sync_gen #(
    .CNT_W (10), .CLK_DIV (1),
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1), .H_POL (1),
    .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1), .V_POL (1)
  ) u_dut_b (
    .clk       (clk),
    .reset     (rst_b),
    .en        (en_b),
    .p_tick    (b_p_tick),
    .hsync     (b_hsync),
    .vsync     (b_vsync),
    .video_on  (b_video_on),
    .pixel_x   (b_px),
    .pixel_y   (b_py),
    .line_end  (b_line_end),
    .frame_end (b_frame_end)
  );

  // Expected outputs after an enabled edge, from n enabled clks since reset release
  function automatic exp_t model(input int n, input int div,
                                 input int ha, input int hfp, input int hs, input int hbp, input int hpol,
                                 input int va, input int vfp, input int vs, input int vbp, input int vpol);
    exp_t e;
    int ht, vt, t, x, y;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    t  = n / div;
    x  = t % ht;
    y  = (t / ht) % vt;
    e.p_tick    = ((n % div) == div - 1);
    e.hsync     = (x >= ha + hfp && x < ha + hfp + hs) ? (hpol != 0) : (hpol == 0);
    e.vsync     = (y >= va + vfp && y < va + vfp + vs) ? (vpol != 0) : (vpol == 0);
    e.video_on  = (x < ha) && (y < va);
    e.line_end  = e.p_tick && (x == ht - 1);
    e.frame_end = e.line_end && (y == vt - 1);
    e.px        = 10'(x);
    e.py        = 10'(y);
    return e;
  endfunction

  function automatic exp_t idle_val(input int hpol, input int vpol);
    exp_t e;
    e           = '0;
    e.hsync     = (hpol == 0);
    e.vsync     = (vpol == 0);
    return e;
  endfunction

  task automatic cmp_sb(input string tag, input exp_t got, input exp_t exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed x=%0d y=%0d flags=%b expected x=%0d y=%0d flags=%b", tag,
             got.px, got.py, got[25:20], exp.px, exp.py, exp[25:20]);
    end
  endtask

  task automatic check(input string tag, input int got, input int exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Push predictions for the coming edge, clock once, then pop and compare both DUTs
  task automatic cycle();
    exp_t e;
    if (rst_a) begin
      e = idle_val(0, 0); na = 0;
    end else if (en_a) begin
      e = model(na, 4, 640, 16, 96, 48, 0, 480, 10, 2, 33, 0); na++;
    end else begin
      e = la; e.p_tick = 1'b0; e.line_end = 1'b0; e.frame_end = 1'b0;
    end
    la = e;
    qa.push_back(e);
    if (rst_b) begin
      e = idle_val(1, 1); nb = 0;
    end else if (en_b) begin
      e = model(nb, 1, 4, 1, 1, 1, 1, 2, 1, 1, 1, 1); nb++;
    end else begin
      e = lb; e.p_tick = 1'b0; e.line_end = 1'b0; e.frame_end = 1'b0;
    end
    lb = e;
    qb.push_back(e);
    @(posedge clk);
    #1;
    cmp_sb("sb_a", {a_p_tick, a_hsync, a_vsync, a_video_on, a_line_end, a_frame_end, a_px, a_py},
           qa.pop_front());
    cmp_sb("sb_b", {b_p_tick, b_hsync, b_vsync, b_video_on, b_line_end, b_frame_end, b_px, b_py},
           qb.pop_front());
  endtask

  initial begin
    int k, hs_low, le_cnt;
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
    na = 0; nb = 0; la = '0; lb = '0;

    // Reset state
    repeat (3) cycle();
    check("rst_a_hsync", int'(a_hsync), 1);
    check("rst_b_hsync", int'(b_hsync), 0);
    check("rst_a_video_on", int'(a_video_on), 0);

    // Release: first p_tick CLK_DIV clks later
    rst_a = 1'b0; rst_b = 1'b0;
    k = 0;
    do begin cycle(); k++; end while (a_p_tick !== 1'b1 && k < 20);
    check("a_first_tick_clks", k, 4);

    // Mid-line asynchronous reset at pixel_x=300
    for (int i = 0; i < 2000 && a_px != 10'd300; i++) cycle();
    check("a_reach_x300", int'(a_px), 300);
    #2 rst_a = 1'b1;
    #1;
    check("a_async_rst_hsync", int'(a_hsync), 1);
    check("a_async_rst_vsync", int'(a_vsync), 1);
    check("a_async_rst_video", int'(a_video_on), 0);
    check("a_async_rst_x", int'(a_px), 0);
    check("a_async_rst_tick", int'(a_p_tick), 0);
    repeat (2) cycle();
    rst_a = 1'b0;
    k = 0;
    do begin cycle(); k++; end while (a_p_tick !== 1'b1 && k < 20);
    check("a_rerelease_tick_clks", k, 4);

    // en gating at pixel_x=100
    for (int i = 0; i < 2000 && !(a_px == 10'd100 && a_p_tick); i++) cycle();
    check("a_reach_x100", int'(a_px), 100);
    en_a = 1'b0;
    repeat (10) cycle();
    check("a_hold_x", int'(a_px), 100);
    check("a_hold_tick", int'(a_p_tick), 0);
    en_a = 1'b1;
    k = 0;
    do begin cycle(); k++; end while (a_p_tick !== 1'b1 && k < 20);
    check("a_resume_phase", k, 4);
    check("a_resume_x", int'(a_px), 101);

    // One full line window: 96 sync pixels and one line strobe
    hs_low = 0; le_cnt = 0;
    for (int i = 0; i < 3200; i++) begin
      cycle();
      if (a_hsync === 1'b0) hs_low++;
      if (a_line_end === 1'b1) le_cnt++;
    end
    check("a_hsync_low_clks", hs_low, 384);
    check("a_line_end_per_line", le_cnt, 1);

    // Line period and return to x=0
    for (int i = 0; i < 3300 && a_line_end !== 1'b1; i++) cycle();
    check("a_line_end_x", int'(a_px), 799);
    k = 0;
    do begin cycle(); k++; end while (a_line_end !== 1'b1 && k < 3300);
    check("a_line_period", k, 3200);
    k = 0;
    do begin cycle(); k++; end while (a_p_tick !== 1'b1 && k < 8);
    check("a_wrap_x", int'(a_px), 0);

    // video_on falls at pixel_x=640
    for (int i = 0; i < 3300 && a_px != 10'd640; i++) cycle();
    check("a_video_off_640", int'(a_video_on), 0);

    // Tiny config: simultaneous wrap and frame period
    for (int i = 0; i < 40 && b_frame_end !== 1'b1; i++) cycle();
    check("b_frame_end_line_end", int'(b_line_end), 1);
    check("b_frame_end_x", int'(b_px), 6);
    check("b_frame_end_y", int'(b_py), 4);
    k = 0;
    do begin cycle(); k++; end while (b_frame_end !== 1'b1 && k < 40);
    check("b_frame_period", k, 35);
    cycle();
    check("b_after_frame_x", int'(b_px), 0);
    check("b_after_frame_y", int'(b_py), 0);

    // Reset during vsync line
    for (int i = 0; i < 40 && b_py != 10'd3; i++) cycle();
    check("b_vsync_line3", int'(b_vsync), 1);
    #2 rst_b = 1'b1;
    #1;
    check("b_async_rst_vsync", int'(b_vsync), 0);
    check("b_async_rst_y", int'(b_py), 0);
    repeat (2) cycle();
    rst_b = 1'b0;
    cycle();
    check("b_restart_tick", int'(b_p_tick), 1);
    check("b_restart_x", int'(b_px), 0);
    repeat (80) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
